uart_rx_8n1: RTL and testbench

- UART receiver for 8 data bits, no parity, 1 stop bit (8N1). It is the receive-side counterpart of the team's uart_tx_8n1 transmitter.
- Runs directly on the 100 MHz system clock. A bit-period counter replaces a divided baud clock.
- Sits between the FTDI TX line (ftdi_tx at top level) and user logic.
- Delivers each received byte with a one-cycle valid strobe. Flags framing errors.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 28 ++
 rtl/uart_rx_8n1.sv | 141 ++++++++++++++
 tb/tb_uart_rx_8n1.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, frame width and
// ASCII digit bounds used by the loopback demo.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } uart_state_e;

    localparam int         DATA_BITS = 8;
    localparam logic [7:0] ASCII_0   = 8'd48;
    localparam logic [7:0] ASCII_9   = 8'd57;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// reset to RST_VAL so an idle-high line does not look like an edge.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver clocked by the system clock; a bit-period counter
// locates mid-bit sample points. Emits one-cycle valid / framing-error strobes.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    output logic       rxerr,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic             rx_s;
    uart_state_e      state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       rxbyte_q,  rxbyte_d;
    logic             rxvalid_q, rxvalid_d;
    logic             rxerr_q,   rxerr_d;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // Next-state and datapath decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rxbyte_d  = rxbyte_q;
        rxvalid_d = 1'b0;
        rxerr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // A start bit that is high again at its midpoint was noise.
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rxbyte_d  = shift_q;
                        rxvalid_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        rxerr_d = 1'b1;
                        state_d = BRK;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            BRK: begin
                // Park here until the line idles so a held-low line errors once.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BRK;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            rxbyte_q  <= 8'h00;
            rxvalid_q <= 1'b0;
            rxerr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rxbyte_q  <= rxbyte_d;
            rxvalid_q <= rxvalid_d;
            rxerr_q   <= rxerr_d;
        end
    end

    assign rxbyte  = rxbyte_q;
    assign rxvalid = rxvalid_q;
    assign rxerr   = rxerr_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed self-checking bench for uart_rx_8n1 at 16 clocks per bit:
// a table of single frames plus hand-written multi-cycle corner sequences.
module tb_uart_rx_8n1;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rxbyte;
    logic       rxvalid;
    logic       rxerr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          vcount = 0;
    int          ecount = 0;
    int          overlap_cnt = 0;
    int          valid_cyc = 0;
    int          fall_cyc = 0;
    logic        busy_at_valid = 1'b0;
    logic [7:0]  got_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[6];

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rxbyte  (rxbyte),
        .rxvalid (rxvalid),
        .rxerr   (rxerr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rxvalid) begin
            vcount++;
            valid_cyc = cyc;
            busy_at_valid = busy;
            got_q.push_back(rxbyte);
        end
        if (rxerr) ecount++;
        if (rxvalid && rxerr) overlap_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        fall_cyc = cyc;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cycles(CPB);
        end
        rx = stop_bit;
        wait_cycles(CPB);
    endtask

    initial begin
        int v0, e0, lat, busy_cnt;

        vecs[0] = '{8'h35, 1'b1, 1, 0, 8'h35};
        vecs[1] = '{8'hA5, 1'b0, 0, 1, 8'h35};
        vecs[2] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[5] = '{8'h81, 1'b0, 0, 1, 8'hFF};

        // Reset state
        wait_cycles(4);
        check("reset_rxbyte", int'(rxbyte), 0);
        check("reset_rxvalid", int'(rxvalid), 0);
        check("reset_rxerr", int'(rxerr), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        wait_cycles(4);

        // Single-frame table
        for (int k = 0; k < 6; k++) begin
            v0 = vcount;
            e0 = ecount;
            send_frame(vecs[k].data, vecs[k].stop_bit);
            rx = 1'b1;
            wait_cycles(24);
            check($sformatf("vec%0d_valid_pulses", k), vcount - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_err_pulses", k), ecount - e0, vecs[k].exp_err);
            check($sformatf("vec%0d_rxbyte", k), int'(rxbyte), int'(vecs[k].exp_byte));
            check($sformatf("vec%0d_busy_idle", k), int'(busy), 0);
            if (vecs[k].exp_valid == 1) begin
                lat = valid_cyc - fall_cyc - 1;
                check($sformatf("vec%0d_latency_in_window", k), int'(lat >= 153 && lat <= 155), 1);
                check($sformatf("vec%0d_busy_at_valid", k), int'(busy_at_valid), 0);
            end
        end

        // Back-to-back '0'..'9' with no idle gap
        got_q.delete();
        v0 = vcount;
        for (int i = 0; i < 10; i++) send_frame(8'h30 + 8'(i), 1'b1);
        rx = 1'b1;
        wait_cycles(30);
        check("stream_count", vcount - v0, 10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) check($sformatf("stream_byte%0d", i), int'(got_q[i]), 8'h30 + i);
            else check($sformatf("stream_byte%0d_missing", i), 0, 8'h30 + i);
        end

        // Short glitch: 5 low clocks
        v0 = vcount;
        e0 = ecount;
        busy_cnt = 0;
        @(negedge clk);
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) rx = 1'b1;
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("glitch_valid", vcount - v0, 0);
        check("glitch_err", ecount - e0, 0);
        check("glitch_busy_bounded", int'(busy_cnt >= 1 && busy_cnt <= 8), 1);
        check("glitch_idle", int'(busy), 0);

        // Break: line low for 40 bit times
        e0 = ecount;
        v0 = vcount;
        @(negedge clk);
        rx = 1'b0;
        wait_cycles(40 * CPB);
        check("break_single_err", ecount - e0, 1);
        check("break_busy_held", int'(busy), 1);
        rx = 1'b1;
        wait_cycles(8);
        check("break_release_idle", int'(busy), 0);
        check("break_no_valid", vcount - v0, 0);
        wait_cycles(16);

        // Reset during data bit 4 of 8'hFF
        v0 = vcount;
        e0 = ecount;
        @(negedge clk);
        rx = 1'b0;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(4 * CPB + 8);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rxbyte", int'(rxbyte), 0);
        check("rst_mid_rxvalid", int'(rxvalid), 0);
        check("rst_mid_rxerr", int'(rxerr), 0);
        check("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        wait_cycles(8 * CPB);
        check("rst_abort_no_valid", vcount - v0, 0);
        check("rst_abort_no_err", ecount - e0, 0);
        send_frame(8'h12, 1'b1);
        rx = 1'b1;
        wait_cycles(24);
        check("post_rst_valid", vcount - v0, 1);
        check("post_rst_rxbyte", int'(rxbyte), 8'h12);

        check("valid_err_never_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
